// File: rtl/ps2_key_tx.sv
// Device-side PS/2 keyboard transmitter: one request sends make code, 0xF0, make code,
// generating the PS/2 clock and retransmitting a frame interrupted by host inhibit.
module ps2_key_tx #(
  parameter int unsigned HALF_PER = 1667,
  parameter int unsigned GAP      = 1667
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] make_code_i,
  input  logic       ps2c_i,
  output logic       ps2c_oe_o,
  output logic       ps2d_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       retry_o
);

  localparam int unsigned CNT_MAX = (HALF_PER > GAP) ? HALF_PER : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PER - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  // Released clock needs two sync flops plus rise time before sc is trustworthy
  localparam logic [CNT_W-1:0] INH_FIRST = CNT_W'(3);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUS,
    HIGH,
    LOW
  } state_e;

  state_e           state_q;
  logic             sync1_q;
  logic             sc_q;
  logic [7:0]       code_q;
  logic [1:0]       byte_idx_q;
  logic [3:0]       bit_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ps2c_oe_q;
  logic             ps2d_oe_q;
  logic             busy_q;
  logic             done_q;
  logic             retry_q;

  logic [7:0]       data_c;
  logic [15:0]      frame_c;
  logic [3:0]       bit_idx_d;
  logic             inhibit_c;

  // Bits above the stop bit are padded with 1 so the trailing high phase releases data
  assign data_c    = (byte_idx_q == 2'd1) ? 8'hF0 : code_q;
  assign frame_c   = {5'h1F, 1'b1, ~^data_c, data_c, 1'b0};
  assign bit_idx_d = bit_idx_q + 4'd1;
  assign inhibit_c = !sc_q && (bit_idx_q <= 4'd10) && (cnt_q >= INH_FIRST);

  // Two-flop synchroniser for the bus clock line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sc_q    <= 1'b1;
    end else begin
      sync1_q <= ps2c_i;
      sc_q    <= sync1_q;
    end
  end

  // Transmit FSM with registered line enables and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= 8'h00;
      byte_idx_q <= 2'd0;
      bit_idx_q  <= 4'd0;
      cnt_q      <= '0;
      ps2c_oe_q  <= 1'b0;
      ps2d_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      retry_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      retry_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // done_q high means busy is still considered asserted this cycle
          if (start_i && !done_q) begin
            code_q     <= make_code_i;
            byte_idx_q <= 2'd0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= WAIT_BUS;
          end
        end
        WAIT_BUS: begin
          if (!sc_q) begin
            cnt_q <= '0;
          end else if (cnt_q == GAP_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= 4'd0;
            ps2d_oe_q <= 1'b1;
            state_q   <= HIGH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (inhibit_c) begin
            cnt_q     <= '0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            retry_q   <= 1'b1;
            state_q   <= WAIT_BUS;
          end else if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (bit_idx_q == 4'd11) begin
              if (byte_idx_q == 2'd2) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                byte_idx_q <= byte_idx_q + 2'd1;
                state_q    <= WAIT_BUS;
              end
            end else begin
              ps2c_oe_q <= 1'b1;
              state_q   <= LOW;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_d;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= ~frame_c[bit_idx_d];
            state_q   <= HIGH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2c_oe_o = ps2c_oe_q;
  assign ps2d_oe_o = ps2d_oe_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign retry_o   = retry_q;

endmodule
